// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding the write side of an async FIFO.
// Grants one requester at a time for up to BURST_MAX words, stalling on full.
module fifo_wr_arbiter #(
  parameter int D_SIZE    = 8,
  parameter int N_REQ     = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                       w_clk,
  input  logic                       w_rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*D_SIZE-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_last,
  input  logic                       w_full,
  output logic [N_REQ-1:0]           gnt,
  output logic                       w_inc,
  output logic [D_SIZE-1:0]          w_data,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic [15:0]                wr_count
);

  localparam int OW = $clog2(N_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [N_REQ-1:0] r_gnt;
  logic [OW-1:0]    r_owner;
  logic [BW-1:0]    r_burst;
  logic [15:0]      r_wr_count;

  logic             w_found;
  logic [OW-1:0]    w_sel;
  logic [OW:0]      w_idx;
  logic [BW-1:0]    w_burst_nx;
  logic             w_release;
  logic             w_own_req;

  // Search starts just after the last owner so every pending requester
  // gets a turn before the same one is granted again.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_owner;
    w_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = {1'b0, r_owner} + (OW+1)'(k);
      if (w_idx >= (OW+1)'(N_REQ))
        w_idx = w_idx - (OW+1)'(N_REQ);
      if (!w_found && req[w_idx[OW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[OW-1:0];
      end
    end
  end

  assign w_own_req  = req[r_owner];
  assign w_burst_nx = r_burst + BW'(1);
  assign w_release  = ~w_own_req
                    | (w_inc & (req_last[r_owner]
                    | (w_burst_nx == BW'(BURST_MAX))));

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found)   w_nstate = S_GRANT;
      S_GRANT: if (w_release) w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state == S_GRANT);
    w_inc  = busy & w_own_req & ~w_full;
    w_data = req_data[r_owner*D_SIZE +: D_SIZE];
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      r_gnt      <= '0;
      r_owner    <= OW'(N_REQ - 1);
      r_burst    <= '0;
      r_wr_count <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_found) begin
          r_gnt   <= N_REQ'(1) << w_sel;
          r_owner <= w_sel;
          r_burst <= '0;
        end
      end else begin
        if (w_inc)     r_burst <= w_burst_nx;
        if (w_release) r_gnt   <= '0;
      end
      if (w_inc) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign gnt      = r_gnt;
  assign owner    = r_owner;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corners,
// random traffic against a behavioural model, and counter wrap.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  last;
  logic        full;
  logic [3:0]  gnt;
  logic        inc;
  logic [7:0]  wdata;
  logic        busy;
  logic [1:0]  owner;
  logic [15:0] wrc;

  logic        rst2;
  logic [1:0]  req2;
  logic [15:0] data2;
  logic [1:0]  last2;
  logic        full2;
  logic [1:0]  gnt2;
  logic        inc2;
  logic [7:0]  wdata2;
  logic        busy2;
  logic [0:0]  owner2;
  logic [15:0] wrc2;

  int n_chk;
  int n_fail;

  bit m_busy;
  int m_owner;
  int m_burst;
  int m_cnt;

  fifo_wr_arbiter #(.D_SIZE(8), .N_REQ(4), .BURST_MAX(4)) u_dut (
    .w_clk(clk), .w_rst(rst_n), .req(req), .req_data(req_data),
    .req_last(last), .w_full(full), .gnt(gnt), .w_inc(inc),
    .w_data(wdata), .busy(busy), .owner(owner), .wr_count(wrc)
  );

  fifo_wr_arbiter #(.D_SIZE(8), .N_REQ(2), .BURST_MAX(255)) u_wrap (
    .w_clk(clk), .w_rst(rst2), .req(req2), .req_data(data2),
    .req_last(last2), .w_full(full2), .gnt(gnt2), .w_inc(inc2),
    .w_data(wdata2), .busy(busy2), .owner(owner2), .wr_count(wrc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int slice(input logic [31:0] d, input int i);
    logic [31:0] t;
    t = d >> (i * 8);
    return int'(t[7:0]);
  endfunction

  task automatic m_reset();
    m_busy  = 1'b0;
    m_owner = 3;
    m_burst = 0;
    m_cnt   = 0;
  endtask

  task automatic mchk();
    bit e_inc;
    e_inc = m_busy && req[m_owner] && !full;
    chk("m_gnt", int'(gnt), m_busy ? (1 << m_owner) : 0);
    chk("m_inc", int'(inc), int'(e_inc));
    chk("m_busy", int'(busy), int'(m_busy));
    chk("m_owner", int'(owner), m_owner);
    chk("m_wrc", int'(wrc), m_cnt);
    chk("m_wdata", int'(wdata), slice(req_data, m_owner));
  endtask

  // Model: pick next pending requester after the last owner; a grant
  // ends on a last word, a full burst, or a dropped request.
  task automatic m_upd();
    bit found;
    int i;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        i = (m_owner + k) % 4;
        if (!found && req[i]) begin
          found   = 1'b1;
          m_owner = i;
          m_burst = 0;
          m_busy  = 1'b1;
        end
      end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0;
    end else if (!full) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_burst++;
      if (last[m_owner] || m_burst == 4) m_busy = 1'b0;
    end
  endtask

  task automatic look();
    @(negedge clk);
    mchk();
  endtask

  task automatic adv();
    @(posedge clk);
    m_upd();
    #1;
    req_data = $urandom;
  endtask

  task automatic do_reset();
    req  = '0;
    last = '0;
    full = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_inc", int'(inc), 0);
    chk("rst_owner", int'(owner), 3);
    chk("rst_wrc", int'(wrc), 0);
    chk("rst_wdata", int'(wdata), slice(req_data, 3));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] r;
    logic [3:0] l;
    logic       f;
    int         g;
    int         i;
    int         o;
    int         c;
  } vec_t;

  task automatic run_table();
    vec_t tbl[6];
    tbl[0] = '{r:4'b0100, l:4'b0000, f:1'b0, g:0, i:0, o:3, c:0};
    tbl[1] = '{r:4'b0100, l:4'b0000, f:1'b0, g:4, i:1, o:2, c:0};
    tbl[2] = '{r:4'b0100, l:4'b0000, f:1'b0, g:4, i:1, o:2, c:1};
    tbl[3] = '{r:4'b0100, l:4'b0100, f:1'b0, g:4, i:1, o:2, c:2};
    tbl[4] = '{r:4'b0000, l:4'b0000, f:1'b0, g:0, i:0, o:2, c:3};
    tbl[5] = '{r:4'b0000, l:4'b0000, f:1'b0, g:0, i:0, o:2, c:3};
    for (int k = 0; k < 6; k++) begin
      req  = tbl[k].r;
      last = tbl[k].l;
      full = tbl[k].f;
      look();
      chk("tbl_gnt", int'(gnt), tbl[k].g);
      chk("tbl_inc", int'(inc), tbl[k].i);
      chk("tbl_owner", int'(owner), tbl[k].o);
      chk("tbl_wrc", int'(wrc), tbl[k].c);
      chk("tbl_wdata", int'(wdata), slice(req_data, tbl[k].o));
      adv();
    end
  endtask

  task automatic run_rr();
    int ord[5];
    ord = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      look();
      chk("rr_idle", int'(gnt), 0);
      adv();
      for (int w = 0; w < 4; w++) begin
        look();
        chk("rr_gnt", int'(gnt), 1 << ord[g]);
        chk("rr_inc", int'(inc), 1);
        adv();
      end
    end
    look();
    chk("rr_count", int'(wrc), 20);
    req = '0;
    adv();
  endtask

  task automatic run_stall();
    do_reset();
    req = 4'b0010;
    look();
    adv();
    look();
    chk("st_first", int'(inc), 1);
    adv();
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      look();
      chk("st_inc", int'(inc), 0);
      chk("st_gnt", int'(gnt), 2);
      chk("st_wrc", int'(wrc), 1);
      adv();
    end
    full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      look();
      chk("st_resume", int'(inc), 1);
      adv();
    end
    look();
    chk("st_end_gnt", int'(gnt), 0);
    chk("st_end_wrc", int'(wrc), 4);
    req = '0;
    adv();
  endtask

  task automatic run_abandon();
    do_reset();
    req = 4'b1000;
    look();
    adv();
    look();
    chk("ab_gnt", int'(gnt), 8);
    adv();
    req = 4'b0111;
    look();
    chk("ab_hold", int'(gnt), 8);
    chk("ab_noinc", int'(inc), 0);
    adv();
    look();
    chk("ab_rel", int'(gnt), 0);
    chk("ab_wrc", int'(wrc), 1);
    adv();
    look();
    chk("ab_next", int'(gnt), 1);
    req = '0;
    adv();
  endtask

  task automatic run_midrst();
    do_reset();
    req = 4'b1111;
    look();
    adv();
    look();
    adv();
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mr_gnt", int'(gnt), 0);
    chk("mr_inc", int'(inc), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_wdata", int'(wdata), slice(req_data, 3));
    @(posedge clk);
    #2;
    chk("mr_hold", int'(inc), 0);
    rst_n = 1'b1;
    #1;
    look();
    adv();
    look();
    chk("mr_regrant", int'(gnt), 1);
    adv();
  endtask

  task automatic run_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      req  = 4'($urandom);
      last = 4'($urandom) & 4'($urandom);
      full = ($urandom_range(4) == 0);
      look();
      adv();
    end
  endtask

  task automatic run_wrap();
    int acc;
    int cyc;
    int k;
    rst2  = 1'b0;
    req2  = '0;
    last2 = '0;
    full2 = 1'b0;
    data2 = 16'hA55A;
    @(posedge clk);
    @(negedge clk);
    rst2 = 1'b1;
    req2 = 2'b01;
    acc  = 0;
    cyc  = 0;
    while (acc < 65535 && cyc < 70000) begin
      @(negedge clk);
      if (inc2) acc++;
      cyc++;
    end
    chk("wrap_budget", acc, 65535);
    @(negedge clk);
    chk("wrap_pre", int'(wrc2), 65535);
    chk("wrap_wdata", int'(wdata2), 'h5A);
    k = 0;
    while (!inc2 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("wrap_wait", int'(inc2), 1);
    @(posedge clk);
    #1;
    chk("wrap_zero", int'(wrc2), 0);
    req2 = '0;
  endtask

  task automatic run_main();
    rst_n    = 1'b1;
    req_data = $urandom;
    m_reset();
    do_reset();
    run_table();
    run_rr();
    run_stall();
    run_abandon();
    run_midrst();
    run_random();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    fork
      run_main();
      run_wrap();
    join
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
